// File: rtl/logic8_sequencer.sv
// Sequencer for the logic8 processor: loads A/B, then runs up to DEPTH stored {F,R} operations
// by driving logic8's active-low LoadA/LoadB/Execute strobes, Din, F and R.
module logic8_sequencer #(
    parameter int DEPTH     = 8,
    parameter int EXEC_HOLD = 12,
    parameter int EXEC_GAP  = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [4:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic [7:0]    a_init,
    input  logic [7:0]    b_init,
    input  logic          do_load,
    input  logic          start,
    input  logic          abort,
    output logic          LoadA,
    output logic          LoadB,
    output logic          Execute,
    output logic [7:0]    Din,
    output logic [2:0]    F,
    output logic [1:0]    R,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step
);

    localparam int TW = $clog2((EXEC_HOLD > EXEC_GAP) ? EXEC_HOLD : EXEC_GAP) + 1;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    // IDLE wait start | LDA/LDB strobe low | *_GAP strobe high | FETCH setup F/R | EXEC Execute low | GAP Execute high | FIN done
    typedef enum logic [3:0] {IDLE, LDA, LDA_GAP, LDB, LDB_GAP, FETCH, EXEC, GAP, FIN} state_t;

    state_t        state;
    logic [4:0]    prog [DEPTH];
    logic [AW:0]   len_q;
    logic [AW:0]   idx;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [TW-1:0] tmr;

    logic [AW:0]   len_in;
    logic [AW:0]   fetch_idx;
    logic [4:0]    fetch_word;
    logic          fetch_ok;

    // F/R are registered, so the entry for the next FETCH is looked up one edge early.
    // A write landing on the same edge as start is forwarded so the new entry is used.
    always_comb begin
        len_in     = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
        fetch_idx  = (state == GAP) ? idx + 1'b1 : '0;
        fetch_word = prog[fetch_idx[AW-1:0]];
        if (state == IDLE && prog_we && prog_addr == '0)
            fetch_word = prog_data;
        fetch_ok   = fetch_idx < ((state == IDLE) ? len_in : len_q);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            LoadA   <= 1'b1;
            LoadB   <= 1'b1;
            Execute <= 1'b1;
            Din     <= '0;
            F       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            step    <= '0;
            len_q   <= '0;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tmr     <= '0;
            for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
        end else begin
            done <= 1'b0;
            if (prog_we && state == IDLE)
                prog[prog_addr] <= prog_data;

            if (abort && state != IDLE) begin
                state   <= IDLE;
                LoadA   <= 1'b1;
                LoadB   <= 1'b1;
                Execute <= 1'b1;
                Din     <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (start) begin
                        len_q <= len_in;
                        a_q   <= a_init;
                        b_q   <= b_init;
                        idx   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        if (do_load) begin
                            state <= LDA;
                            LoadA <= 1'b0;
                            Din   <= a_init;
                        end else begin
                            state <= FETCH;
                            if (fetch_ok) {F, R} <= fetch_word;
                        end
                    end
                    LDA: begin
                        state <= LDA_GAP;
                        LoadA <= 1'b1;
                    end
                    LDA_GAP: begin
                        state <= LDB;
                        LoadB <= 1'b0;
                        Din   <= b_q;
                    end
                    LDB: begin
                        state <= LDB_GAP;
                        LoadB <= 1'b1;
                        Din   <= '0;
                    end
                    LDB_GAP: begin
                        state <= FETCH;
                        if (fetch_ok) {F, R} <= fetch_word;
                    end
                    FETCH: begin
                        if (idx == len_q) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= EXEC;
                            Execute <= 1'b0;
                            tmr     <= TW'(EXEC_HOLD - 1);
                        end
                    end
                    EXEC: begin
                        if (tmr == '0) begin
                            state   <= GAP;
                            Execute <= 1'b1;
                            tmr     <= TW'(EXEC_GAP - 1);
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    GAP: begin
                        if (tmr == '0) begin
                            state <= FETCH;
                            idx   <= fetch_idx;
                            if (fetch_ok) begin
                                {F, R} <= fetch_word;
                                step   <= fetch_idx[AW-1:0];
                            end
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
